// File: rtl/hex_display_bank.sv
// Memory-mapped seven-segment display bank with blanking, blink and LZS.
// Optional INC register at BASE_ADDR+8 enabled by HEXBANK_INC_EN.
module hex_display_bank #(
  parameter int                 DBITS     = 32,
  parameter int                 NDIGITS   = 4,
  parameter logic [DBITS-1:0]   BASE_ADDR = 32'hF000_0000,
  parameter int                 BLINK_DIV = 25000000
) (
  input  logic                   clk,
  input  logic                   reset,
  inout  wire  [DBITS-1:0]       dbus,
  input  logic [DBITS-1:0]       address,
  input  logic                   wrtEn,
  output logic [7*NDIGITS-1:0]   HEX
);

  localparam int DW = 4 * NDIGITS;
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [DBITS-1:0] CTRL_ADDR = BASE_ADDR + DBITS'(4);
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  logic [DW-1:0]        data;
  logic [NDIGITS-1:0]   blank;
  logic [NDIGITS-1:0]   blink;
  logic                 lzs;
  logic [CW-1:0]        cnt;
  logic                 ph;
  logic [7*NDIGITS-1:0] hex_q;
  logic [7*NDIGITS-1:0] hex_nxt;
  logic [DBITS-1:0]     rdata;
  logic                 sel_data;
  logic                 sel_ctrl;
  logic                 sel_inc;
  logic                 rd_en;
  logic                 zabove;
  logic                 dark;
  logic                 unused_bits;

  assign sel_data = (address == BASE_ADDR);
  assign sel_ctrl = (address == CTRL_ADDR);
`ifdef HEXBANK_INC_EN
  assign sel_inc  = (address == BASE_ADDR + DBITS'(8));
`else
  assign sel_inc  = 1'b0;
`endif
  assign rd_en = !wrtEn && (sel_data || sel_ctrl || sel_inc);
  assign dbus  = rd_en ? rdata : {DBITS{1'bz}};
  assign HEX   = hex_q;
  assign unused_bits = ^dbus[DBITS-1:17];

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Data register: direct write, or accumulate through INC when enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
    end else if (wrtEn && sel_data) begin
      data <= dbus[DW-1:0];
    end else if (wrtEn && sel_inc) begin
      data <= data + dbus[DW-1:0];
    end
  end

  // Control masks and blink prescaler; a CTRL write restarts the blink visible
  always_ff @(posedge clk) begin
    if (reset) begin
      blank <= '0;
      blink <= '0;
      lzs   <= 1'b0;
      cnt   <= '0;
      ph    <= 1'b0;
    end else if (wrtEn && sel_ctrl) begin
      blank <= dbus[NDIGITS-1:0];
      blink <= dbus[8 +: NDIGITS];
      lzs   <= dbus[16];
      cnt   <= '0;
      ph    <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      ph  <= ~ph;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Read mux: zero-extended register, blink phase reported in bit 31 of CTRL
  always_comb begin
    rdata = '0;
    if (sel_data || sel_inc) begin
      rdata[DW-1:0] = data;
    end else if (sel_ctrl) begin
      rdata[NDIGITS-1:0]   = blank;
      rdata[8 +: NDIGITS]  = blink;
      rdata[16]            = lzs;
      rdata[31]            = ph;
    end
  end

  // Per-digit segment pattern; zabove tracks "this and all higher nibbles zero"
  always_comb begin
    hex_nxt = '1;
    zabove  = 1'b1;
    dark    = 1'b0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      zabove = zabove && (data[4*i +: 4] == 4'h0);
      dark   = blank[i] || (blink[i] && ph) || (lzs && (i > 0) && zabove);
      hex_nxt[7*i +: 7] = dark ? 7'h7F : glyph(data[4*i +: 4]);
    end
  end

  // Registered segment outputs, all segments off in reset
  always_ff @(posedge clk) begin
    if (reset) begin
      hex_q <= '1;
    end else begin
      hex_q <= hex_nxt;
    end
  end

endmodule

// File: doc/hex_display_bank.md
Name: hex_display_bank

Overview:
- Memory-mapped multi-digit seven-segment display controller on the shared bidirectional processor data bus.
- Parametrised in digit count and base address.
- Adds per-digit blanking, per-digit blink driven by an internal prescaler, and leading-zero suppression.
- Sits beside the other bus devices; drives the board HEX outputs from registered segment values.

Parameters:
- DBITS, 32, bus data/address width.
- NDIGITS, 4, number of digits driven; legal range 1..8.
- BASE_ADDR, 32'hF000_0000, address of the DATA register. CTRL is at BASE_ADDR+4; INC is at BASE_ADDR+8 (optional feature only).
- BLINK_DIV, 25000000, clk cycles per blink half-period; must be ≥2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- dbus  inout  DBITS  shared data bus.
- address  input  DBITS  bus address.
- wrtEn  input  1  1 = write cycle, 0 = read cycle.
- HEX  output  7*NDIGITS  active-low segments; digit i is HEX[7*i+6:7*i], bit order gfedcba.

Behaviour:
- Registers:
  - DATA: 4*NDIGITS bits; digit i = DATA[4i+3:4i].
  - CTRL: BLANK[7:0] = CTRL[7:0]; BLINK[7:0] = CTRL[15:8]; LZS = CTRL[16]. Mask bits at or above NDIGITS are not stored and read 0.
  - blink counter cnt, range 0..BLINK_DIV-1.
  - blink phase ph.
- Reset (synchronous, active-high): DATA=0, CTRL=0, cnt=0, ph=0, HEX all ones (all segments off).
- Address decode: exact equality on the full DBITS address. No access for any other address.
- Write (address match and wrtEn=1), committed on the clk edge:
  - DATA takes dbus[4*NDIGITS-1:0].
  - CTRL takes dbus[16:0] masked to implemented bits, and forces cnt=0 and ph=0 (blink restarts visible).
- Read (address match and wrtEn=0): dbus is driven combinationally with the zero-extended register.
  - DATA read returns the DATA value.
  - CTRL read returns the stored bits, plus the current ph in bit 31.
  - Otherwise dbus is all Z. The block never drives dbus while wrtEn=1.
- Prescaler: cnt increments every cycle. At cnt==BLINK_DIV-1, cnt wraps to 0 and ph toggles. A CTRL write takes priority over the wrap.
- Digit i is dark (7'b1111111) if any of the following holds; otherwise it shows the hex glyph of its nibble:
  - BLANK[i]=1;
  - BLINK[i]=1 and ph=1;
  - LZS=1 and i>0 and nibbles i..NDIGITS-1 are all zero. Digit 0 is never suppressed, so a value of 0 shows a single "0".
- Glyphs (active-low, gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Latency: HEX is registered and reflects register/ph state one cycle after it changes.
  - A DATA write at edge N appears on HEX at edge N+1.
  - The first edge after reset deasserts shows all digits as "0" (all blanks off).
- Reset asserted mid-blink or mid-access: the reset values above take effect at that edge, and pending write data is discarded.

Optional Feature:
- Macro: HEXBANK_INC_EN.
- Defined: the INC register at BASE_ADDR+8 is decoded.
  - Write: DATA <= DATA + dbus[4*NDIGITS-1:0], modulo 2^(4*NDIGITS), plain binary wrap.
  - Read: returns the zero-extended DATA.
- Undefined: BASE_ADDR+8 is not decoded; no register update and dbus stays Z there.

Test Plan:
- Reset, then idle: HEX all ones during reset; one cycle after reset deasserts, each digit = 1000000; read of BASE → dbus=0; read of BASE+4 → 0.
- NDIGITS=4: write 32'h0000_12AF to BASE → next cycle HEX0=0001110(F), HEX1=0001000(A), HEX2=0100100(2), HEX3=1111001(1); read of BASE → 32'h0000_12AF.
- Blink: BLINK_DIV=4, write CTRL=32'h0000_0200 → digit1 visible for 4 cycles, dark for 4, repeating; CTRL read bit31 tracks ph; a second CTRL write mid-dark → digit1 visible on the next cycle and the counter restarts.
- Blank and leading-zero suppression: DATA=16'h0050, CTRL=32'h0001_0001 → digits 3 and 2 dark (LZS), digit1=0010010, digit0 dark (BLANK); DATA=0 with LZS only → digit0 shows "0", others dark.
- Bus hygiene: read at BASE+12, write at BASE+4 with wrtEn=1, and an unrelated address → dbus=Z from the block in all three; an unmatched write leaves DATA unchanged.
- HEXBANK_INC_EN, NDIGITS=4: DATA=16'hFFFE, write 3 to BASE+8 → DATA=16'h0001, HEX shows 0001. Macro undefined: the same write leaves DATA=16'hFFFE.
